// File: rtl/mytt_pkg.sv
// Shared constants for the tt_um_alexlowl_my_tt_project counter block.
// Latency: n/a (constants only).
// Backpressure: n/a.
package mytt_pkg;

  // Datapath width of the count and compare registers
  localparam int CNT_W = 8;

  // Prescale selections: divide-by factor applied to the count step rate
  localparam logic [1:0] PRESC_DIV1   = 2'b00;
  localparam logic [1:0] PRESC_DIV4   = 2'b01;
  localparam logic [1:0] PRESC_DIV16  = 2'b10;
  localparam logic [1:0] PRESC_DIV256 = 2'b11;

  // Bit positions inside ui_in
  localparam int UI_CNT_EN   = 0;
  localparam int UI_UP       = 1;
  localparam int UI_LOAD_CNT = 2;
  localparam int UI_LOAD_CMP = 3;
  localparam int UI_PSEL_LO  = 4;
  localparam int UI_PSEL_HI  = 5;
  localparam int UI_WRAP     = 6;

endpackage

// File: rtl/mytt_prescaler.sv
// Free-running 8-bit prescaler with a tap mux producing the count-step tick.
// Latency: tick is combinational from the current prescaler value; counter advances every enabled clk.
// Backpressure: none; holds entirely while ena=0 (tick forced low).
module mytt_prescaler
  import mytt_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [1:0] sel,
  output logic       tick
);

  logic [7:0] pre;

  // Free-running counter; wraps 255->0 naturally, frozen when the block is deselected
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= 8'h00;
    end else if (ena) begin
      pre <= pre + 8'd1;
    end
  end

  // Tick fires on the last cycle of each divide period so div1 steps every cycle
  always_comb begin
    tick = 1'b0;
    case (sel)
      PRESC_DIV1:   tick = 1'b1;
      PRESC_DIV4:   tick = (pre[1:0] == 2'b11);
      PRESC_DIV16:  tick = (pre[3:0] == 4'hF);
      PRESC_DIV256: tick = (pre == 8'hFF);
      default:      tick = 1'b0;
    endcase
    tick = tick & ena;
  end

endmodule

// File: rtl/tt_um_alexlowl_my_tt_project.sv
// Tiny Tapeout user block: 8-bit up/down counter with prescaler, load, wrap/saturate and compare register.
// Latency: loads and count steps appear on uo_out one clk after the edge; PWM flag is one further clk behind.
// Backpressure: none; ena=0 freezes all state while outputs keep driving. Optional PWM output via MYTT_PWM_EN.
module tt_um_alexlowl_my_tt_project
  import mytt_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic [CNT_W-1:0] cmp;
  logic [CNT_W-1:0] load_dat;
  logic             tick;

  logic       cnt_en;
  logic       up;
  logic       load_cnt;
  logic       load_cmp;
  logic       wrap;
  logic [1:0] psel;

  assign cnt_en   = ui_in[UI_CNT_EN];
  assign up       = ui_in[UI_UP];
  assign load_cnt = ui_in[UI_LOAD_CNT];
  assign load_cmp = ui_in[UI_LOAD_CMP];
  assign wrap     = ui_in[UI_WRAP];
  assign psel     = ui_in[UI_PSEL_HI:UI_PSEL_LO];

`ifdef MYTT_PWM_EN
  // uio[7] is an output in this build, so only the low seven pins carry load data
  assign load_dat = {1'b0, uio_in[6:0]};
`else
  assign load_dat = uio_in;
`endif

  mytt_prescaler u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .sel   (psel),
    .tick  (tick)
  );

  // Next-count selection: load beats stepping, stepping beats hold
  always_comb begin
    count_nxt = count;
    if (load_cnt) begin
      count_nxt = load_dat;
    end else if (cnt_en && tick) begin
      if (up) begin
        if (count == 8'hFF) begin
          count_nxt = wrap ? 8'h00 : 8'hFF;
        end else begin
          count_nxt = count + 8'd1;
        end
      end else begin
        if (count == 8'h00) begin
          count_nxt = wrap ? 8'hFF : 8'h00;
        end else begin
          count_nxt = count - 8'd1;
        end
      end
    end
  end

  // Count and compare registers; both may load the same data on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      cmp   <= '0;
    end else if (ena) begin
      count <= count_nxt;
      if (load_cmp) begin
        cmp <= load_dat;
      end
    end
  end

  assign uo_out = count;

`ifdef MYTT_PWM_EN
  logic pwm;

  // Registered compare flag, refreshed every clk from the current registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm <= 1'b0;
    end else begin
      pwm <= (count < cmp);
    end
  end

  assign uio_oe  = 8'h80;
  assign uio_out = {pwm, 7'b0000000};
`else
  assign uio_oe  = 8'h00;
  assign uio_out = 8'h00;
`endif

  // Reserved input bit (and compare register when it has no observer) deliberately unused
  logic unused_ok;
  assign unused_ok = &{1'b0, ui_in[7], uio_in[7], cmp};

endmodule

// File: tb/tb_tt_um_alexlowl_my_tt_project.sv
// Self-checking bench for tt_um_alexlowl_my_tt_project: directed scenarios plus randomized traffic
// compared against a cycle-count based behavioural model. Honours MYTT_PWM_EN if defined.
module tb_tt_um_alexlowl_my_tt_project;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  tt_um_alexlowl_my_tt_project dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state: plain integers
  int m_cycles;   // enabled clocks since reset
  int m_cnt;
  int m_cmp;
  int m_pwm;

  int divs [4] = '{1, 4, 16, 256};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int load_val(input logic [7:0] d);
`ifdef MYTT_PWM_EN
    return int'(d[6:0]);
`else
    return int'(d);
`endif
  endfunction

  function automatic int exp_oe();
`ifdef MYTT_PWM_EN
    return 32'h80;
`else
    return 0;
`endif
  endfunction

  function automatic int exp_uio_out();
`ifdef MYTT_PWM_EN
    return m_pwm * 128;
`else
    return 0;
`endif
  endfunction

  // One clock edge of the reference behaviour, computed from the rules directly
  task automatic model_edge();
    int div;
    bit tick;
    int nc;
    m_pwm = (m_cnt < m_cmp) ? 1 : 0;
    if (ena) begin
      div  = divs[ui_in[5:4]];
      tick = ((m_cycles % div) == div - 1);
      nc   = m_cnt;
      if (ui_in[2]) begin
        nc = load_val(uio_in);
      end else if (ui_in[0] && tick) begin
        if (ui_in[1]) nc = (m_cnt == 255) ? (ui_in[6] ? 0 : 255) : m_cnt + 1;
        else          nc = (m_cnt == 0)   ? (ui_in[6] ? 255 : 0) : m_cnt - 1;
      end
      if (ui_in[3]) m_cmp = load_val(uio_in);
      m_cnt    = nc;
      m_cycles = m_cycles + 1;
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".uo_out"}, 32'(uo_out), 32'(m_cnt));
    chk({tag, ".uio_oe"}, 32'(uio_oe), 32'(exp_oe()));
    chk({tag, ".uio_out"}, 32'(uio_out), 32'(exp_uio_out()));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_outs(tag);
  endtask

  // Asserts reset away from a clock edge, checks the immediate clear, releases on a falling edge
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    m_cycles = 0;
    m_cnt    = 0;
    m_cmp    = 0;
    m_pwm    = 0;
    chk("reset.uo_out", 32'(uo_out), 32'h00);
    chk("reset.uio_oe", 32'(uio_oe), 32'(exp_oe()));
    chk("reset.uio_out", 32'(uio_out), 32'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int seen_ff;
    int seen_00;
    int ones;
    int exp_seq [7] = '{4, 3, 2, 1, 0, 0, 0};

    ui_in  = 8'($urandom);
    uio_in = 8'($urandom);
    #3;
    do_reset();

    // Div1 wrap up-count across the 255 -> 0 boundary
    ui_in  = 8'h43;
    uio_in = 8'h00;
    seen_ff = 0;
    seen_00 = 0;
    for (int i = 0; i < 260; i++) begin
      step("wrap_up");
      if (uo_out == 8'hFF) seen_ff = 1;
      if (seen_ff == 1 && uo_out == 8'h00) seen_00 = 1;
    end
    chk("wrap_up.saw_ff", 32'(seen_ff), 32'd1);
    chk("wrap_up.saw_00_after_ff", 32'(seen_00), 32'd1);
    chk("wrap_up.final", 32'(uo_out), 32'h04);

    // Load then saturating down-count
    @(negedge clk);
    uio_in = 8'h05;
    ui_in  = 8'h05;
    step("load");
    chk("load.value", 32'(uo_out), 32'h05);
    ui_in = 8'h01;
    for (int i = 0; i < 7; i++) begin
      step("sat_down");
      chk($sformatf("sat_down.%0d", i), 32'(uo_out), 32'(exp_seq[i]));
    end

    // Priority: load wins over an enabled step
    ui_in  = 8'h07;
    uio_in = 8'hA0;
    step("prio");
`ifdef MYTT_PWM_EN
    chk("prio.value", 32'(uo_out), 32'h20);
`else
    chk("prio.value", 32'(uo_out), 32'hA0);
`endif

    // Mid-count reset, then div4 from a restarted prescaler
    ui_in = 8'h43;
    repeat (5) step("pre_reset");
    #2;
    do_reset();
    ui_in = 8'h13;
    repeat (8) step("div4");
    chk("div4.after8", 32'(uo_out), 32'h02);

    // Deselected: everything holds
    ena = 1'b0;
    ui_in = 8'h17;
    uio_in = 8'h99;
    repeat (10) step("ena_low");
    chk("ena_low.hold", 32'(uo_out), 32'h02);
    ena = 1'b1;
    ui_in = 8'h13;
    repeat (4) step("div4_resume");
    chk("div4_resume.value", 32'(uo_out), 32'h03);

`ifdef MYTT_PWM_EN
    do_reset();
    ui_in  = 8'h08;
    uio_in = 8'h40;
    step("pwm_loadcmp");
    ui_in = 8'h43;
    step("pwm_settle");
    ones = 0;
    for (int i = 0; i < 256; i++) begin
      step("pwm_run");
      ones += int'(uio_out[7]);
    end
    chk("pwm.duty64", 32'(ones), 32'd64);
    ui_in  = 8'h4B;
    uio_in = 8'h00;
    step("pwm_cmp0");
    ui_in = 8'h43;
    step("pwm_settle0");
    ones = 0;
    for (int i = 0; i < 256; i++) begin
      step("pwm_run0");
      ones += int'(uio_out[7]);
    end
    chk("pwm.duty0", 32'(ones), 32'd0);
`endif

    // Randomized traffic against the model, with occasional resets
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] u;
      u = 8'($urandom);
      u[2] = ($urandom_range(0, 9) == 0);
      u[3] = ($urandom_range(0, 9) == 0);
      ui_in  = u;
      uio_in = 8'($urandom);
      ena    = ($urandom_range(0, 7) != 0);
      step("rand");
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
